// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - CSR read-modify-write initiator between execute stage and CSR block
// Optional read-only write check enabled by defining CSR_ACCESS_CHECK_EN.
module csr_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] instruction,
    input  logic [31:0] rs1Value,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        rdWriteEnable,
    output logic [4:0]  rdIndex,
    output logic [31:0] rdData,
    output logic        csrReadEnable,
    output logic        csrWriteEnable,
    output logic [11:0] csrAddress,
    output logic [31:0] csrWriteData,
    input  logic [31:0] csrReadData
);

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;

    state_t      state;
    logic [1:0]  opKind;
    logic [31:0] operand;
    logic [31:0] oldValue;
    logic        readNeeded;
    logic        writeNeeded;

    logic [2:0]  decFunct3;
    logic [4:0]  decRs1;
    logic [4:0]  decRd;
    logic [31:0] decOperand;
    logic        decRead;
    logic        decWrite;
    logic        decIllegal;
    logic        readOnlyHit;
    logic        unusedOpcode;

    assign unusedOpcode = ^instruction[6:0];

    // Decode straight from the pipeline inputs; only used on the accepting cycle.
    always_comb begin
        decFunct3  = instruction[14:12];
        decRs1     = instruction[19:15];
        decRd      = instruction[11:7];
        decOperand = decFunct3[2] ? {27'b0, decRs1} : rs1Value;
        decRead    = !((decFunct3[1:0] == 2'b01) && (decRd == 5'd0));
        decWrite   = (decFunct3[1:0] == 2'b01) || (decRs1 != 5'd0);
`ifdef CSR_ACCESS_CHECK_EN
        readOnlyHit = decWrite && (instruction[31:30] == 2'b11);
`else
        readOnlyHit = 1'b0;
`endif
        decIllegal = (decFunct3[1:0] == 2'b00) || readOnlyHit;
    end

    function automatic logic [31:0] mergeValue(input logic [1:0]  kind,
                                               input logic [31:0] old,
                                               input logic [31:0] opnd);
        case (kind)
            2'b01:   return opnd;
            2'b10:   return old | opnd;
            default: return old & ~opnd;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            opKind         <= 2'b00;
            operand        <= 32'h0;
            oldValue       <= 32'h0;
            readNeeded     <= 1'b0;
            writeNeeded    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            illegal        <= 1'b0;
            rdWriteEnable  <= 1'b0;
            rdIndex        <= 5'd0;
            rdData         <= 32'h0;
            csrReadEnable  <= 1'b0;
            csrWriteEnable <= 1'b0;
            csrAddress     <= 12'h000;
            csrWriteData   <= 32'h0;
        end else begin
            // Strobes and completion flags are single-cycle pulses by default.
            csrReadEnable  <= 1'b0;
            csrWriteEnable <= 1'b0;
            done           <= 1'b0;
            illegal        <= 1'b0;
            rdWriteEnable  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opKind      <= decFunct3[1:0];
                        operand     <= decOperand;
                        oldValue    <= 32'h0;
                        readNeeded  <= decRead;
                        writeNeeded <= decWrite;
                        rdIndex     <= decRd;
                        csrAddress  <= instruction[31:20];
                        busy        <= 1'b1;
                        if (decIllegal) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            illegal <= 1'b1;
                            rdData  <= 32'h0;
                        end else if (decRead) begin
                            state         <= READ;
                            csrReadEnable <= 1'b1;
                        end else begin
                            state          <= WRITE;
                            csrWriteEnable <= 1'b1;
                            csrWriteData   <= decOperand;
                        end
                    end
                end
                READ: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    oldValue <= csrReadData;
                    if (writeNeeded) begin
                        state          <= WRITE;
                        csrWriteEnable <= 1'b1;
                        csrWriteData   <= mergeValue(opKind, csrReadData, operand);
                    end else begin
                        state         <= DONE;
                        done          <= 1'b1;
                        rdWriteEnable <= (rdIndex != 5'd0);
                        rdData        <= csrReadData;
                    end
                end
                WRITE: begin
                    state         <= DONE;
                    done          <= 1'b1;
                    rdWriteEnable <= readNeeded && (rdIndex != 5'd0);
                    rdData        <= oldValue;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// tb/tb_csr_access_unit.sv - self-checking bench for csr_access_unit (table, corner sequences, random vs model)
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] instruction;
    logic [31:0] rs1Value;
    logic        busy;
    logic        done;
    logic        illegal;
    logic        rdWriteEnable;
    logic [4:0]  rdIndex;
    logic [31:0] rdData;
    logic        csrReadEnable;
    logic        csrWriteEnable;
    logic [11:0] csrAddress;
    logic [31:0] csrWriteData;
    logic [31:0] csrReadData = 32'h0;

    csr_access_unit dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .instruction    (instruction),
        .rs1Value       (rs1Value),
        .busy           (busy),
        .done           (done),
        .illegal        (illegal),
        .rdWriteEnable  (rdWriteEnable),
        .rdIndex        (rdIndex),
        .rdData         (rdData),
        .csrReadEnable  (csrReadEnable),
        .csrWriteEnable (csrWriteEnable),
        .csrAddress     (csrAddress),
        .csrWriteData   (csrWriteData),
        .csrReadData    (csrReadData)
    );

    always #5 clk = ~clk;

    // Behavioural CSR block: read data returned the cycle after the strobe.
    logic [31:0] csrMem [0:4095];
    logic        preloadEn = 1'b0;
    logic [11:0] preloadAddr = 12'h0;
    logic [31:0] preloadData = 32'h0;

    always @(posedge clk) begin
        if (csrReadEnable)  csrReadData <= csrMem[csrAddress];
        if (csrWriteEnable) csrMem[csrAddress] <= csrWriteData;
        if (preloadEn)      csrMem[preloadAddr] <= preloadData;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] enc(input logic [11:0] csr, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {csr, rs1, f3, rd, 7'h73};
    endfunction

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        preloadAddr = a;
        preloadData = d;
        preloadEn   = 1'b1;
        @(posedge clk); #1;
        preloadEn   = 1'b0;
    endtask

    int          obsDoneCyc, obsReadCyc, obsWriteCyc, obsReadCnt, obsWriteCnt;
    logic        obsIll, obsRdWE, obsOverlap, obsAddrBad, obsBusyLow;
    logic [4:0]  obsRdIndex;
    logic [31:0] obsRdData, obsWData;

    // Issue one instruction and record what happens on both sides; pokeCycle>0 re-pulses start while busy.
    task automatic runOp(input logic [31:0] instr, input logic [31:0] rv, input int pokeCycle);
        @(posedge clk); #1;
        instruction = instr;
        rs1Value    = rv;
        start       = 1'b1;
        obsDoneCyc = 0; obsReadCyc = 0; obsWriteCyc = 0; obsReadCnt = 0; obsWriteCnt = 0;
        obsIll = 1'b0; obsRdWE = 1'b0; obsOverlap = 1'b0; obsAddrBad = 1'b0; obsBusyLow = 1'b0;
        obsRdIndex = 5'd0; obsRdData = 32'h0; obsWData = 32'h0;
        for (int cyc = 1; cyc <= 10 && obsDoneCyc == 0; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == pokeCycle);
            if (start) begin
                instruction = enc(12'h7C0, 5'd9, 3'b001, 5'd9);
                rs1Value    = 32'hFFFF_FFFF;
            end
            if (!busy) obsBusyLow = 1'b1;
            if (csrReadEnable && csrWriteEnable) obsOverlap = 1'b1;
            if (csrReadEnable) begin
                obsReadCnt++;
                if (obsReadCyc == 0) obsReadCyc = cyc;
                if (csrAddress !== instr[31:20]) obsAddrBad = 1'b1;
            end
            if (csrWriteEnable) begin
                obsWriteCnt++;
                if (obsWriteCyc == 0) obsWriteCyc = cyc;
                obsWData = csrWriteData;
                if (csrAddress !== instr[31:20]) obsAddrBad = 1'b1;
            end
            if (done) begin
                obsDoneCyc = cyc;
                obsIll     = illegal;
                obsRdWE    = rdWriteEnable;
                obsRdIndex = rdIndex;
                obsRdData  = rdData;
            end
        end
        start = 1'b0;
    endtask

    task automatic checkObs(input string tag, input logic [31:0] instr, input int expLat,
                            input logic expIll, input logic expRdWE, input logic [31:0] expRdData,
                            input logic expRead, input logic expWrite, input logic [31:0] expWData,
                            input logic [31:0] expMem);
        check({tag, ".latency"}, 32'(obsDoneCyc), 32'(expLat));
        check({tag, ".illegal"}, 32'(obsIll), 32'(expIll));
        check({tag, ".rdWriteEnable"}, 32'(obsRdWE), 32'(expRdWE));
        check({tag, ".rdIndex"}, 32'(obsRdIndex), 32'(instr[11:7]));
        if (expRdWE) check({tag, ".rdData"}, obsRdData, expRdData);
        check({tag, ".readCount"}, 32'(obsReadCnt), expRead ? 32'd1 : 32'd0);
        if (expRead) check({tag, ".readCycle"}, 32'(obsReadCyc), 32'd1);
        check({tag, ".writeCount"}, 32'(obsWriteCnt), expWrite ? 32'd1 : 32'd0);
        if (expWrite) begin
            check({tag, ".writeCycle"}, 32'(obsWriteCyc), expRead ? 32'd3 : 32'd1);
            check({tag, ".writeData"}, obsWData, expWData);
        end
        check({tag, ".strobeOverlap"}, 32'(obsOverlap), 32'd0);
        check({tag, ".strobeAddress"}, 32'(obsAddrBad), 32'd0);
        check({tag, ".busy"}, 32'(obsBusyLow), 32'd0);
        check({tag, ".csrValue"}, csrMem[instr[31:20]], expMem);
    endtask

    // Reference model: outcome of one CSR instruction from its fields, operand and the old CSR value.
    task automatic modelCheck(input string tag, input logic [31:0] instr, input logic [31:0] rv,
                              input logic [31:0] old);
        logic [2:0]  f3;
        logic [4:0]  rs1, rd;
        logic [11:0] csr;
        logic [31:0] opnd, newVal;
        logic        reads, writes, ill;
        int          lat;
        f3  = instr[14:12];
        rs1 = instr[19:15];
        rd  = instr[11:7];
        csr = instr[31:20];
        opnd   = f3[2] ? 32'(rs1) : rv;
        ill    = (f3 == 3'd0) || (f3 == 3'd4);
        reads  = !((f3 == 3'd1 || f3 == 3'd5) && rd == 5'd0);
        writes = (f3 == 3'd1 || f3 == 3'd5) || (rs1 != 5'd0);
`ifdef CSR_ACCESS_CHECK_EN
        if (writes && csr >= 12'hC00) ill = 1'b1;
`endif
        if (ill) begin
            reads  = 1'b0;
            writes = 1'b0;
        end
        case (f3)
            3'd1, 3'd5: newVal = opnd;
            3'd2, 3'd6: newVal = old | opnd;
            default:    newVal = old & ~opnd;
        endcase
        lat = ill ? 1 : 1 + (reads ? 2 : 0) + (writes ? 1 : 0);
        checkObs(tag, instr, lat, ill, reads && (rd != 5'd0), old, reads, writes, newVal,
                 writes ? newVal : old);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1v;
        logic [31:0] oldv;
        int          lat;
        logic        ill;
        logic        rdWE;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic        seen;
        logic [31:0] instr, rv, old;
        logic [11:0] csr;

        vecs[0]  = '{enc(12'h340, 5'd7, 3'b001, 5'd5), 32'hDEADBEEF, 32'h12345678, 4, 1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF};
        vecs[1]  = '{enc(12'h300, 5'd3, 3'b010, 5'd6), 32'h0000000F, 32'h000000F0, 4, 1'b0, 1'b1, 1'b1, 1'b1, 32'h000000FF};
        vecs[2]  = '{enc(12'h305, 5'd5, 3'b111, 5'd7), 32'h0,        32'h000000FF, 4, 1'b0, 1'b1, 1'b1, 1'b1, 32'h000000FA};
        vecs[3]  = '{enc(12'hC00, 5'd0, 3'b010, 5'd1), 32'h0,        32'h00000064, 3, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
`ifdef CSR_ACCESS_CHECK_EN
        vecs[4]  = '{enc(12'hC00, 5'd2, 3'b001, 5'd4), 32'h00000055, 32'h00000077, 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
`else
        vecs[4]  = '{enc(12'hC00, 5'd2, 3'b001, 5'd4), 32'h00000055, 32'h00000077, 4, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000055};
`endif
        vecs[5]  = '{enc(12'h340, 5'd3, 3'b100, 5'd5), 32'h1,        32'h00000033, 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{enc(12'h341, 5'd8, 3'b001, 5'd0), 32'hCAFEF00D, 32'h00000011, 2, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D};
        vecs[7]  = '{enc(12'h300, 5'd0, 3'b010, 5'd0), 32'h0,        32'h00000022, 3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{enc(12'h305, 5'd4, 3'b000, 5'd2), 32'h9,        32'h00000044, 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{enc(12'h342, 5'd31, 3'b101, 5'd0), 32'hFFFFFFFF, 32'h00000099, 2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000001F};
        vecs[10] = '{enc(12'h343, 5'd1, 3'b011, 5'd3), 32'h0F0F0F0F, 32'hFFFF0000, 4, 1'b0, 1'b1, 1'b1, 1'b1, 32'hF0F00000};
        vecs[11] = '{enc(12'h344, 5'd0, 3'b110, 5'd2), 32'h0,        32'h0000ABCD, 3, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};

        rst = 1'b1;
        start = 1'b0;
        instruction = 32'h0;
        rs1Value = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.illegal", 32'(illegal), 32'd0);
        check("reset.rdWriteEnable", 32'(rdWriteEnable), 32'd0);
        check("reset.rdIndex", 32'(rdIndex), 32'd0);
        check("reset.rdData", rdData, 32'd0);
        check("reset.csrReadEnable", 32'(csrReadEnable), 32'd0);
        check("reset.csrWriteEnable", 32'(csrWriteEnable), 32'd0);
        check("reset.csrAddress", 32'(csrAddress), 32'd0);
        check("reset.csrWriteData", csrWriteData, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            preload(vecs[i].instr[31:20], vecs[i].oldv);
            runOp(vecs[i].instr, vecs[i].rs1v, 0);
            checkObs($sformatf("vec%0d", i), vecs[i].instr, vecs[i].lat, vecs[i].ill, vecs[i].rdWE,
                     vecs[i].oldv, vecs[i].rd, vecs[i].wr, vecs[i].wdata,
                     vecs[i].wr ? vecs[i].wdata : vecs[i].oldv);
        end

        // start pulsed while busy must not disturb the running op nor start another.
        preload(12'h7C0, 32'h00005A5A);
        preload(12'h300, 32'h000000F0);
        runOp(enc(12'h300, 5'd3, 3'b010, 5'd6), 32'h0000000F, 2);
        checkObs("busyStart", enc(12'h300, 5'd3, 3'b010, 5'd6), 4, 1'b0, 1'b1, 32'h000000F0,
                 1'b1, 1'b1, 32'h000000FF, 32'h000000FF);
        check("busyStart.otherCsr", csrMem[12'h7C0], 32'h00005A5A);

        // Reset during CAPTURE: no write may follow.
        preload(12'h340, 32'hAAAA5555);
        @(posedge clk); #1;
        instruction = enc(12'h340, 5'd7, 3'b001, 5'd5);
        rs1Value = 32'hDEADBEEF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midReset.busy", 32'(busy), 32'd0);
        check("midReset.done", 32'(done), 32'd0);
        check("midReset.strobes", {30'd0, csrReadEnable, csrWriteEnable}, 32'd0);
        check("midReset.flags", {30'd0, illegal, rdWriteEnable}, 32'd0);
        check("midReset.csrAddress", 32'(csrAddress), 32'd0);
        check("midReset.rdData", rdData, 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (csrWriteEnable || csrReadEnable || done || busy) seen = 1'b1;
        end
        check("midReset.quiet", 32'(seen), 32'd0);
        check("midReset.csrValue", csrMem[12'h340], 32'hAAAA5555);

        // Back-to-back: start in the DONE cycle is ignored, accepted the cycle after.
        preload(12'h341, 32'h0);
        runOp(enc(12'h341, 5'd8, 3'b001, 5'd0), 32'h01234567, 0);
        check("b2b.firstLatency", 32'(obsDoneCyc), 32'd2);
        instruction = enc(12'h340, 5'd3, 3'b100, 5'd5);
        start = 1'b1;
        @(posedge clk); #1;
        check("b2b.ignoredBusy", 32'(busy), 32'd0);
        check("b2b.ignoredDone", 32'(done), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b.acceptedDone", 32'(done), 32'd1);
        check("b2b.acceptedIllegal", 32'(illegal), 32'd1);

        for (int n = 0; n < 150; n++) begin
            csr = ($urandom_range(0, 3) == 0) ? {2'b11, 10'($urandom)} : 12'($urandom_range(0, 12'hBFF));
            instr = enc(csr, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                        3'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom));
            rv  = $urandom;
            old = $urandom;
            preload(csr, old);
            runOp(instr, rv, ($urandom_range(0, 1) == 1) ? 1 : 0);
            modelCheck($sformatf("rand%0d", n), instr, rv, old);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

- Initiator side of the core's CSR bus: executes one SYSTEM-opcode CSR instruction (CSRRW/S/C and immediate forms) as a read-modify-write sequence.
- Drives `csrReadEnable`/`csrWriteEnable`/`csrAddress`/`csrWriteData` into the CSR block and returns the old CSR value for writeback to `rd`.
- Sits between the core's execute stage and the CSR block.
- Reports illegal-instruction conditions to the trap logic.

## Interface
Parameters: none.

Clock and reset:
- `clk` in 1: core clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.

Pipeline side:
- `start` in 1: accept `instruction`/`rs1Value`; sampled only in IDLE.
- `instruction` in 32: full CSR instruction (csr = [31:20], rs1/uimm = [19:15], funct3 = [14:12], rd = [11:7]).
- `rs1Value` in 32: register-file value of rs1.
- `busy` out 1: high in every non-IDLE state.
- `done` out 1: one-cycle completion pulse.
- `illegal` out 1: valid with `done`; instruction was not executed.
- `rdWriteEnable` out 1: valid with `done`; write `rdData` to `rdIndex`.
- `rdIndex` out 5: latched rd.
- `rdData` out 32: old CSR value.

CSR bus side:
- `csrReadEnable` out 1: read strobe.
- `csrWriteEnable` out 1: write strobe.
- `csrAddress` out 12: CSR address.
- `csrWriteData` out 32: new CSR value.
- `csrReadData` in 32: read data, valid the cycle after `csrReadEnable`.

## Operation
Decode from latched instruction:
- `funct3` 001/010/011 = RW/RS/RC with operand `rs1Value`.
- `funct3` 101/110/111 = RWI/RSI/RCI with operand `{27'b0, uimm}`.
- `funct3` 000/100 → illegal.

Skip rules:
- Read skipped for RW/RWI when rd = x0.
- Write skipped for RS/RC/RSI/RCI when rs1/uimm field = 0.

Write data:
- RW: `operand`.
- RS: `old | operand`.
- RC: `old & ~operand`.

FSM states IDLE, READ, CAPTURE, WRITE, DONE:
- IDLE, `start`=1: latch instruction fields and operand. Next state:
  - DONE if illegal.
  - else READ if read performed.
  - else WRITE.
- READ: `csrReadEnable`=1 → CAPTURE.
- CAPTURE: latch `csrReadData` into `oldValue` → WRITE if write performed, else DONE.
- WRITE: `csrWriteEnable`=1, `csrWriteData` per rules → DONE.
- DONE: `done`=1.
  - `rdWriteEnable`=1 iff not illegal, read performed and rd ≠ 0.
  - `rdData`=`oldValue`.
  - → IDLE.

Bus rules:
- `csrReadEnable` and `csrWriteEnable` are never high in the same cycle.
- `csrAddress` holds the latched address from READ through WRITE.
- Strobes are decoded from state registers: glitch-free, one cycle each.

Boundary conditions:
- `start` while busy: ignored; latched fields unchanged.
- `start` in IDLE in the same cycle DONE returns to IDLE: DONE → IDLE takes one cycle, so a back-to-back `start` is accepted the cycle after `done`.
- Both read and write skipped (RW to x0 with rd = x0 cannot occur; RS with rs1 = 0, rd = 0): READ is still performed, because the read is skipped only for RW/RWI. Completes with no writeback.

## Timing
- Reset values of all outputs: 0 (`csrAddress`=12'h000, `rdData`=0). State = IDLE.
- Reset mid-operation: after the reset edge, state = IDLE, all strobes/`done` are 0, and no partial write is issued.
- Latency from `start` cycle (cycle 0) to `done`:
  - full read+write: cycle 4 (READ c1, CAPTURE c2, WRITE c3, DONE c4).
  - read only: cycle 3.
  - write only: cycle 2.
  - illegal: cycle 1.
- Throughput: one instruction per (latency + 1) cycles.

## Configuration
`CSR_ACCESS_CHECK_EN` gates the read-only write check.
- Defined: a write that would be performed to an address with `csrAddress[11:10]`=2'b11 (read-only space) → illegal. No bus strobes; `done`+`illegal` at cycle 1.
- Undefined: no read-only check. The write strobe is issued and the CSR block ignores it. Only funct3 000/100 are illegal.

## Test plan
- CSRRW 0x340, rs1Value=0xDEADBEEF, rd=x5, CSR holds 0x12345678 → `csrReadEnable` c1, `csrWriteEnable` c3 with data 0xDEADBEEF, `done`+`rdWriteEnable` c4 with `rdIndex`=5, `rdData`=0x12345678.
- CSRRS, rs1Value=0x0000000F, old=0x000000F0 → write 0x000000FF. CSRRCI uimm=5, old=0xFF → write 0xFA.
- CSRRS 0xC00, rs1=x0, rd=x1, cycle count 0x64 → no `csrWriteEnable` ever, `done` c3, `rdData`=0x64, `illegal`=0.
- CSRRW 0xC00, rs1=x2 → with macro: `done`+`illegal` c1, no strobes, `rdWriteEnable`=0. Without macro: write strobe at c3, `illegal`=0.
- funct3=100 → `illegal` at c1. CSRRW rd=x0 → no read strobe, write at c1, `done` c2, `rdWriteEnable`=0.
- `rst` asserted during WRITE cycle's preceding CAPTURE → next cycle all outputs 0, IDLE. `start` pulsed while busy → ignored, original op result unchanged.
